// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU with valid/ready handshakes, iterative MUL/MULHU/DIVU/REMU; optional flush port under SEQ_ALU_FLUSH_EN
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
`ifdef SEQ_ALU_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] portA,
  input  logic [WIDTH-1:0] portB,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             negative,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_out;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_a;      // multiplicand for MUL*, divisor for DIV*/REM*
  logic [2*WIDTH-1:0] r_prod;   // {partial sum, remaining multiplier bits}
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;    // dividend bits shift out the top, quotient bits in the bottom

  logic               w_flush;
  logic [SHW-1:0]     w_shamt;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_result;
  logic               w_ovf;
  logic               w_is_iter;
  logic [WIDTH:0]     w_madd;
  logic [2*WIDTH-1:0] w_prod_next;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   w_sub;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;
  logic [WIDTH-1:0]   w_iter_result;

`ifdef SEQ_ALU_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == BUSY);
  assign out       = r_out;
  assign overflow  = r_ovf;
  assign negative  = r_out[WIDTH-1];
  assign zero      = (r_out == '0);

  assign w_shamt   = portB[SHW-1:0];
  assign w_sum     = portA + portB;
  assign w_diff    = portA - portB;
  assign w_is_iter = (op >= 4'd10) && (op <= 4'd13);

  // Single-cycle result and overflow, evaluated straight from the presented operands
  always_comb begin
    w_result = '0;
    w_ovf    = 1'b0;
    case (op)
      4'd0: w_result = portA << w_shamt;
      4'd1: w_result = portA >> w_shamt;
      4'd2: begin
        w_result = w_sum;
        w_ovf    = (portA[WIDTH-1] == portB[WIDTH-1]) && (w_sum[WIDTH-1] != portA[WIDTH-1]);
      end
      4'd3: begin
        w_result = w_diff;
        w_ovf    = (portA[WIDTH-1] != portB[WIDTH-1]) && (w_diff[WIDTH-1] != portA[WIDTH-1]);
      end
      4'd4: w_result = portA & portB;
      4'd5: w_result = portA | portB;
      4'd6: w_result = portA ^ portB;
      4'd7: w_result = ~(portA | portB);
      4'd8: w_result = {{(WIDTH-1){1'b0}}, ($signed(portA) < $signed(portB))};
      4'd9: w_result = {{(WIDTH-1){1'b0}}, (portA < portB)};
      default: w_result = '0;
    endcase
  end

  // One shift-add step and one restoring-divide step; the next-state values also feed the final result
  always_comb begin
    w_madd      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_a} : '0);
    w_prod_next = {w_madd, r_prod[WIDTH-1:1]};
    w_trial     = {r_rem, r_quo[WIDTH-1]};
    // Full-width compare so a zero divisor still yields all-ones quotient and remainder = dividend
    w_qbit      = (w_trial >= {1'b0, r_a});
    w_sub       = w_trial[WIDTH-1:0] - r_a;
    w_rem_next  = w_qbit ? w_sub : w_trial[WIDTH-1:0];
    w_quo_next  = {r_quo[WIDTH-2:0], w_qbit};
    case (r_op)
      OP_MUL:   w_iter_result = w_prod_next[WIDTH-1:0];
      OP_MULHU: w_iter_result = w_prod_next[2*WIDTH-1:WIDTH];
      OP_DIVU:  w_iter_result = w_quo_next;
      default:  w_iter_result = w_rem_next;
    endcase
  end

  // FSM, operand capture, iteration registers and registered result
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_out   <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_prod  <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
    end else if (w_flush) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op <= op;
            if (w_is_iter) begin
              r_a     <= op[2] ? portB : portA;
              r_prod  <= {{WIDTH{1'b0}}, portB};
              r_quo   <= portA;
              r_rem   <= '0;
              r_cnt   <= CNT_W'(WIDTH);
              r_state <= BUSY;
            end else begin
              r_out   <= w_result;
              r_ovf   <= w_ovf;
              r_state <= DONE;
            end
          end
        end
        BUSY: begin
          if (r_op[2]) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
          end else begin
            r_prod <= w_prod_next;
          end
          r_cnt <= r_cnt - CNT_W'(1);
          // Last iteration: register the result from this step so latency is exactly WIDTH+1
          if (r_cnt == CNT_W'(1)) begin
            r_out   <= w_iter_result;
            r_ovf   <= 1'b0;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Width is generic. Existing ops (op codes 0-9) complete in one cycle. Adds iterative multiply and unsigned divide/remainder (op codes 10-13).
- Operands enter and results leave through valid/ready handshakes, so the block can stall the pipeline's EX stage while a long op runs.
- Sits between the ID/EX latch and the EX/MEM latch. Hazard logic uses in_ready/out_valid to stall.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 4 and a power of two.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset, synchronous, active-high.
- in_valid  input  1  operands/op presented.
- in_ready  output  1  block can accept a new op.
- portA  input  WIDTH  operand A.
- portB  input  WIDTH  operand B.
- op  input  4  operation code.
- out_valid  output  1  result registered and held.
- out_ready  input  1  consumer takes result.
- out  output  WIDTH  result.
- negative  output  1  out[WIDTH-1].
- overflow  output  1  signed overflow (ADD/SUB only, else 0).
- zero  output  1  out == 0.
- busy  output  1  iterative op in progress.

Behaviour:
- Op codes:
  - 0 SLL, 1 SRL: shift portA by portB[$clog2(WIDTH)-1:0].
  - 2 ADD, 3 SUB.
  - 4 AND, 5 OR, 6 XOR, 7 NOR.
  - 8 SLT (signed), 9 SLTU: result is 1 or 0, zero-extended.
  - 10 MUL (low WIDTH bits of product), 11 MULHU (high WIDTH bits, unsigned).
  - 12 DIVU, 13 REMU.
  - 14, 15: illegal; single-cycle, out = 0.
- FSM states IDLE, BUSY, DONE. Reset (RST high at a clock edge) forces IDLE from any state, including mid-BUSY. Reset values: out=0, out_valid=0, busy=0, negative=0, overflow=0, zero=1, counter=0.
- in_ready = (state == IDLE). Accept occurs on in_valid && in_ready at an edge; operands and op are captured at that edge.
- IDLE, accept single-cycle op (0-9, 14, 15): result and flags registered; next state DONE. out_valid asserts 1 cycle after accept.
- IDLE, accept op 10-13: operands loaded into internal accumulator/shift registers; counter = WIDTH; next state BUSY; busy=1.
- BUSY: one iteration per cycle.
  - MUL/MULHU: shift-add over a 2*WIDTH-bit product.
  - DIVU/REMU: restoring divide with a WIDTH-bit remainder.
  - Counter decrements each cycle. When the counter reaches 0 (after WIDTH iterations), the result and flags are registered and the FSM goes to DONE. out_valid asserts WIDTH+1 cycles after accept.
- Divide by zero: DIVU out = all ones, REMU out = portA. Still takes WIDTH+1 cycles (latency is fixed, not data-dependent).
- DONE: out, flags and out_valid are held stable until out_valid && out_ready at an edge; then the FSM goes to IDLE and out_valid drops. out keeps its last value.
- No accept in DONE or BUSY; in_valid there is ignored and must be held by the producer.
- overflow:
  - ADD: A and B have the same sign and the result's sign differs.
  - SUB: A and B have different signs and the result's sign differs from A.
  - All other ops: 0.
- negative and zero are computed from the registered out for every op.
- Arithmetic wraps modulo 2^WIDTH; no saturation.

Optional Feature:
- SEQ_ALU_FLUSH_EN defined: adds input port flush (1 bit). flush high at an edge forces IDLE and out_valid=0 from BUSY or DONE. out and flags are not modified. flush takes priority over accept and over the out_ready handshake in the same cycle. RST still has priority over flush.
- SEQ_ALU_FLUSH_EN undefined: no flush port; only RST aborts an op.

Test Plan:
- WIDTH=32, ADD A=0x7FFFFFFF, B=1, out_ready=1 -> out_valid 1 cycle after accept; out=0x80000000, overflow=1, negative=1, zero=0.
- SLT A=0xFFFFFFFF, B=0 -> out=1; SLTU same operands -> out=0, zero=1.
- MUL A=0x0001_0000, B=0x0001_0000 -> out=0 after 33 cycles, zero=1; MULHU same operands -> out=1. in_ready=0 and busy=1 throughout BUSY.
- DIVU A=100, B=7 -> out=14; REMU -> out=2; DIVU B=0 -> out=0xFFFFFFFF after 33 cycles; REMU B=0 -> out=100.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out stable, in_ready=0, new in_valid ignored. out_ready=1 -> IDLE next cycle, then the pending op is accepted.
- RST asserted on cycle 10 of a DIVU -> next cycle IDLE, out_valid=0, out=0, busy=0. With SEQ_ALU_FLUSH_EN, flush at the same point -> IDLE with the prior out value retained.
